dtmf_tone_generator: RTL and testbench



---
 rtl/dtmf_pkg.sv | 52 +++++
 rtl/dtmf_sine_lut.sv | 49 ++++
 rtl/dtmf_tone_generator.sv | 138 +++++++++++++
 tb/tb_dtmf_tone_generator.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtmf_pkg.sv
// Shared types and constants for the DTMF tone generator: FSM states, DDS tuning
// words for fs = 8 kHz, keypad codes and the quarter-wave sine table generator.
package dtmf_pkg;

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_e;

  localparam int unsigned TW_W    = 16;
  localparam int unsigned MAG_W   = 15;
  localparam int unsigned LUT_AMP = 32767;

  // Low group 697/770/852/941 Hz, high group 1209/1336/1477/1633 Hz.
  localparam logic [TW_W-1:0] ROW_TW [4] = '{16'd5710, 16'd6308, 16'd6980, 16'd7709};
  localparam logic [TW_W-1:0] COL_TW [4] = '{16'd9904, 16'd10945, 16'd12100, 16'd13378};

  localparam logic [3:0] KEY_1    = 4'h0;
  localparam logic [3:0] KEY_2    = 4'h1;
  localparam logic [3:0] KEY_3    = 4'h2;
  localparam logic [3:0] KEY_A    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_B    = 4'h7;
  localparam logic [3:0] KEY_7    = 4'h8;
  localparam logic [3:0] KEY_8    = 4'h9;
  localparam logic [3:0] KEY_9    = 4'hA;
  localparam logic [3:0] KEY_C    = 4'hB;
  localparam logic [3:0] KEY_STAR = 4'hC;
  localparam logic [3:0] KEY_0    = 4'hD;
  localparam logic [3:0] KEY_HASH = 4'hE;
  localparam logic [3:0] KEY_D    = 4'hF;

  // pi in Q30, used only while elaborating the sine table.
  localparam longint PI_FP = 64'sd3373259426;

  // round(LUT_AMP * sin(pi/2 * idx / 2^aw)) via a Q30 Taylor series; elaboration-time only.
  function automatic int unsigned quarter_sine(input int unsigned idx, input int unsigned aw);
    longint x;
    longint x2;
    longint term;
    longint acc;
    x    = (longint'(idx) * PI_FP) >>> (aw + 32'd1);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int k = 1; k < 10; k++) begin
      term = -((term * x2) >>> 30) / longint'(2 * k * (2 * k + 1));
      acc  = acc + term;
    end
    return 32'((acc * longint'(LUT_AMP) + (64'sd1 <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/dtmf_sine_lut.sv
// Quarter-wave sine table with quadrant folding; registered signed output, one cycle latency.
module dtmf_sine_lut
  import dtmf_pkg::*;
#(
  parameter int unsigned LUT_AW = 8,
  parameter int unsigned OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LUT_AW+1:0]       phase_idx,
  output logic signed [OUT_W-1:0] sine
);

  localparam int unsigned DEPTH = 1 << LUT_AW;

  logic [MAG_W-1:0]        rom [DEPTH];
  logic [1:0]              quad;
  logic [LUT_AW-1:0]       addr;
  logic [LUT_AW-1:0]       mirror;
  logic [MAG_W-1:0]        mag;
  logic signed [OUT_W-1:0] mag_s;

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam logic [MAG_W-1:0] ENTRY = MAG_W'(quarter_sine(32'(i), LUT_AW));
    assign rom[i] = ENTRY;
  end

  assign quad   = phase_idx[LUT_AW+1 -: 2];
  assign addr   = phase_idx[LUT_AW-1:0];
  assign mirror = LUT_AW'(0) - addr;
  assign mag_s  = OUT_W'(mag);

  // Odd quadrants read the table backwards; their first entry is the peak, one past the table end.
  always_comb begin
    mag = rom[addr];
    if (quad[0]) begin
      mag = (addr == '0) ? MAG_W'(LUT_AMP) : rom[mirror];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sine <= '0;
    end else begin
      sine <= quad[1] ? -mag_s : mag_s;
    end
  end

endmodule

// File: rtl/dtmf_tone_generator.sv
// Dual-tone DDS generator: one keypad symbol = tone burst then silent gap.
// Optional DTMF_TWIST_EN attenuates the low-group tone to 0.75 for positive twist.
module dtmf_tone_generator
  import dtmf_pkg::*;
#(
  parameter int unsigned PHASE_W      = 16,
  parameter int unsigned LUT_AW       = 8,
  parameter int unsigned OUT_W        = 16,
  parameter int unsigned TONE_SAMPLES = 400,
  parameter int unsigned GAP_SAMPLES  = 400
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_tick,
  input  logic                    start,
  input  logic [3:0]              key,
  output logic signed [OUT_W-1:0] sample,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned MAX_SAMPLES = (TONE_SAMPLES > GAP_SAMPLES) ? TONE_SAMPLES : GAP_SAMPLES;
  localparam int unsigned CNT_W       = $clog2(MAX_SAMPLES + 1);
  localparam int unsigned IDX_W       = LUT_AW + 2;

  state_e                  state;
  logic [3:0]              key_q;
  logic [PHASE_W-1:0]      phase_lo;
  logic [PHASE_W-1:0]      phase_hi;
  logic [PHASE_W-1:0]      tw_lo;
  logic [PHASE_W-1:0]      tw_hi;
  logic [CNT_W-1:0]        cnt;
  logic                    tone_vld;
  logic                    gap_vld;
  logic signed [OUT_W-1:0] sine_lo;
  logic signed [OUT_W-1:0] sine_hi;
  logic signed [OUT_W-1:0] mix_c;

  assign tw_lo = PHASE_W'(ROW_TW[key_q[3:2]]);
  assign tw_hi = PHASE_W'(COL_TW[key_q[1:0]]);

  dtmf_sine_lut #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_lut_lo (
    .clk       (clk),
    .reset     (reset),
    .phase_idx (phase_lo[PHASE_W-1 -: IDX_W]),
    .sine      (sine_lo)
  );

  dtmf_sine_lut #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_lut_hi (
    .clk       (clk),
    .reset     (reset),
    .phase_idx (phase_hi[PHASE_W-1 -: IDX_W]),
    .sine      (sine_hi)
  );

  // Symbol sequencer; a tick in TONE samples the current phases, then advances them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      key_q    <= '0;
      phase_lo <= '0;
      phase_hi <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tone_vld <= 1'b0;
      gap_vld  <= 1'b0;
    end else begin
      done     <= 1'b0;
      tone_vld <= 1'b0;
      gap_vld  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_q    <= key;
            phase_lo <= '0;
            phase_hi <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= TONE;
          end
        end
        TONE: begin
          if (sample_tick) begin
            tone_vld <= 1'b1;
            phase_lo <= phase_lo + tw_lo;
            phase_hi <= phase_hi + tw_hi;
            if (cnt == CNT_W'(TONE_SAMPLES - 1)) begin
              cnt   <= '0;
              state <= GAP;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        GAP: begin
          if (sample_tick) begin
            gap_vld <= 1'b1;
            if (cnt == CNT_W'(GAP_SAMPLES - 1)) begin
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Halving each tone before the add keeps the sum inside the output range.
  always_comb begin
`ifdef DTMF_TWIST_EN
    mix_c = ((sine_lo >>> 1) - (sine_lo >>> 3)) + (sine_hi >>> 1);
`else
    mix_c = (sine_lo >>> 1) + (sine_hi >>> 1);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= tone_vld | gap_vld;
      if (tone_vld) begin
        sample <= mix_c;
      end else if (gap_vld) begin
        sample <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dtmf_tone_generator.sv
// Self-checking bench for dtmf_tone_generator: sine/DDS reference model, per-sample
// scoreboard with latency check, Goertzel spectral checks. Honours DTMF_TWIST_EN.
module tb_dtmf_tone_generator;

  localparam int  TONE  = 400;
  localparam int  GAP   = 400;
  localparam int  TOTAL = TONE + GAP;
  localparam real PI    = 3.14159265358979;
  localparam int  TOL   = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               sample_tick;
  logic               start;
  logic [3:0]         key;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               busy;
  logic               done;

  dtmf_tone_generator #(
    .PHASE_W(16), .LUT_AW(8), .OUT_W(16), .TONE_SAMPLES(TONE), .GAP_SAMPLES(GAP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .start        (start),
    .key          (key),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int value;
    int due;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_count = 0;
  exp_t expq[$];
  int   cap[$];

  real ROW_HZ [4] = '{697.0, 770.0, 852.0, 941.0};
  real COL_HZ [4] = '{1209.0, 1336.0, 1477.0, 1633.0};

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic int tw_of(input real f);
    return $rtoi(f * 65536.0 / 8000.0 + 0.5);
  endfunction

  function automatic int lut_model(input int idx10);
    real x;
    x = 32767.0 * $sin(2.0 * PI * real'(idx10) / 1024.0);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic int mix(input int lo, input int hi);
`ifdef DTMF_TWIST_EN
    return ((lo >>> 1) - (lo >>> 3)) + (hi >>> 1);
`else
    return (lo >>> 1) + (hi >>> 1);
`endif
  endfunction

  function automatic int model_sample(input logic [3:0] k, input int n);
    int plo, phi;
    if (n >= TONE) return 0;
    plo = (n * tw_of(ROW_HZ[k[3:2]])) % 65536;
    phi = (n * tw_of(COL_HZ[k[1:0]])) % 65536;
    return mix(lut_model(plo / 64), lut_model(phi / 64));
  endfunction

  function automatic real gpow(input real f);
    real c, s0, s1, s2;
    s1 = 0.0;
    s2 = 0.0;
    c  = 2.0 * $cos(2.0 * PI * f / 8000.0);
    for (int n = 0; n < TONE; n++) begin
      s0 = real'(cap[n]) + c * s1 - s2;
      s2 = s1;
      s1 = s0;
    end
    return s1 * s1 + s2 * s2 - c * s1 * s2;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every valid sample must be due exactly now and match the model.
  always @(negedge clk) begin
    int   s;
    exp_t e;
    if (sample_valid) begin
      s = int'(sample);
      checks++;
      if (expq.size() == 0 || expq[0].due != cyc) begin
        errors++;
        $display("FAIL sample_timing: valid at cycle %0d, next expected due %0d",
                 cyc, (expq.size() != 0) ? expq[0].due : -1);
      end else begin
        e = expq.pop_front();
        checks++;
        if (s > e.value + TOL || s < e.value - TOL) begin
          errors++;
          $display("FAIL sample_value: cycle %0d got %0d expected %0d", cyc, s, e.value);
        end
      end
      checks++;
      if (s > 32767 || s < -32767) begin
        errors++;
        $display("FAIL sample_range: got %0d limit 32767", s);
      end
      cap.push_back(s);
    end else if (expq.size() != 0 && expq[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL sample_missing: cycle %0d got none expected %0d", cyc, expq[0].value);
      void'(expq.pop_front());
    end
    if (done) done_count++;
  end

  task automatic step(input bit tk, input bit st, input logic [3:0] k);
    @(posedge clk);
    #1;
    sample_tick = tk;
    start       = st;
    key         = k;
  endtask

  task automatic spectrum_check(input logic [3:0] k, input bit strict);
    real p [8];
    real ratio, want, weakest;
    int  br, bc;
    for (int i = 0; i < 4; i++) begin
      p[i]     = gpow(ROW_HZ[i]);
      p[4 + i] = gpow(COL_HZ[i]);
    end
    br = 0;
    bc = 0;
    for (int i = 1; i < 4; i++) begin
      if (p[i] > p[br]) br = i;
      if (p[4 + i] > p[4 + bc]) bc = i;
    end
    chk("peak_row", br, int'(k[3:2]));
    chk("peak_col", bc, int'(k[1:0]));
`ifdef DTMF_TWIST_EN
    want = 0.75;
`else
    want = 1.0;
`endif
    ratio = $sqrt(p[k[3:2]] / p[4 + k[1:0]]);
    checks++;
    if (ratio > want + 0.1 || ratio < want - 0.1) begin
      errors++;
      $display("FAIL twist_ratio: key %0h got %0d/1000 expected %0d/1000",
               k, $rtoi(ratio * 1000.0), $rtoi(want * 1000.0));
    end
    if (strict) begin
      weakest = (p[k[3:2]] < p[4 + k[1:0]]) ? p[k[3:2]] : p[4 + k[1:0]];
      for (int i = 0; i < 8; i++) begin
        if (i != int'(k[3:2]) && i != 4 + int'(k[1:0])) begin
          checks++;
          if (p[i] * 100.0 > weakest) begin
            errors++;
            $display("FAIL leakage: bin %0d got %0d dB below peak expected >= 20",
                     i, $rtoi(10.0 * $log10(weakest / p[i])));
          end
        end
      end
    end
  endtask

  // One symbol: start, TOTAL ticks with random spacing, optional stray start or reset.
  task automatic run_symbol(input logic [3:0] k, input int min_sp, input int max_sp,
                            input int inject_at, input int reset_at,
                            input bit tick_with_start, input bit analyse, input bit strict);
    int   dc0, sp;
    exp_t e;
    dc0 = done_count;
    cap.delete();
    step(tick_with_start, 1'b1, k);
    step(1'b0, 1'b0, k);
    @(negedge clk);
    chk("busy_after_start", int'(busy), 1);
    for (int n = 0; n < TOTAL; n++) begin
      sp = int'($urandom_range(max_sp, min_sp));
      for (int i = 1; i < sp; i++) step(1'b0, 1'b0, k);
      if (n == reset_at) begin
        @(posedge clk);
        #1;
        reset = 1'b1;
        sample_tick = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expq.delete();
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(sample_valid), 0);
        chk("reset_sample", int'(sample), 0);
        chk("reset_done", int'(done), 0);
        repeat (4) step(1'b0, 1'b0, k);
        chk("reset_no_done", done_count - dc0, 0);
        return;
      end
      step(1'b1, n == inject_at, (n == inject_at) ? 4'h5 : k);
      e.value = model_sample(k, n);
      e.due   = cyc + 2;
      expq.push_back(e);
    end
    step(1'b0, 1'b0, k);
    @(negedge clk);
    chk("done_pulse", int'(done), 1);
    chk("busy_with_done", int'(busy), 0);
    step(1'b0, 1'b0, k);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    for (int i = 0; i < 8 && expq.size() != 0; i++) step(1'b0, 1'b0, k);
    chk("drain", expq.size(), 0);
    chk("done_count", done_count - dc0, 1);
    chk("sample_count", cap.size(), TOTAL);
    if (analyse && cap.size() >= TONE) spectrum_check(k, strict);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    sample_tick = 1'b0;
    start       = 1'b0;
    key         = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sample", int'(sample), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Hand-computed pins on the model itself.
    chk("model_tw_697", tw_of(697.0), 5710);
    chk("model_tw_1336", tw_of(1336.0), 10945);
    chk("model_tw_1633", tw_of(1633.0), 13378);
    chk("model_lut_45deg", lut_model(128), 23170);
    chk("model_lut_peak", lut_model(256), 32767);
    chk("model_lut_trough", lut_model(768), -32767);
    chk("model_first_sample", model_sample(4'hD, 0), 0);
`ifdef DTMF_TWIST_EN
    chk("model_mix", mix(32767, -32767), -4096);
`else
    chk("model_mix", mix(32767, -32767), -1);
`endif

    // Ticks while idle produce nothing.
    for (int i = 0; i < 12; i++) begin
      step(i[0], 1'b0, 4'h0);
      @(negedge clk);
      chk("idle_no_valid", int'(sample_valid), 0);
    end

    // Key 1, tick every 10 cycles, tick dropped with start, stray start at sample 100.
    run_symbol(4'h0, 10, 10, 100, -1, 1'b1, 1'b1, 1'b0);
    // Key '0' with dense ticks and strict spectral purity.
    run_symbol(4'hD, 1, 3, -1, -1, 1'b0, 1'b1, 1'b1);
    // Reset mid-burst, then a fresh symbol must restart from phase 0.
    run_symbol(4'($urandom_range(15, 0)), 1, 2, -1, 200, 1'b0, 1'b0, 1'b0);
    run_symbol(4'h7, 1, 1, -1, -1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      run_symbol(4'(k), 1, 2, -1, -1, 1'($urandom_range(1, 0)), 1'b1, 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 4'h3);
      @(negedge clk);
      chk("idle_after_no_valid", int'(sample_valid), 0);
    end
    step(1'b0, 1'b0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
